// File: rtl/single_port_ram.sv
// -----------------------------------------------------------------------------
// single_port_ram
//   Synchronous single-port RAM with one shared read/write address and a
//   registered read port. Depth is 2**addr_w words of data_w bits.
//
//   Write edge: the addressed word takes data_in, and data_out shows data_in
//   on the same edge (write-through). Read edge: data_out takes the contents
//   the word held before the edge (1-cycle latency). Reset clears data_out and
//   every word, and overrides any write on the same edge.
//
// Ports
//   clk       in   1       clock, all actions on rising edge
//   rst       in   1       synchronous active-high reset
//   we        in   1       write enable
//   addr      in   addr_w  word address (read and write)
//   data_in   in   data_w  write data
//   data_out  out  data_w  registered read data
// -----------------------------------------------------------------------------
module single_port_ram #(
  parameter int data_w = 4,
  parameter int addr_w = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [addr_w-1:0] addr,
  input  logic [data_w-1:0] data_in,
  output logic [data_w-1:0] data_out
);

  localparam int Depth = 2 ** addr_w;

  logic [data_w-1:0] mem_q [Depth];
  logic [data_w-1:0] data_out_q;
  logic [data_w-1:0] data_out_d;

  // Write-through: a write returns the new data; a read returns the
  // pre-edge contents of the addressed word.
  always_comb begin
    data_out_d = mem_q[addr];
    if (we) begin
      data_out_d = data_in;
    end
  end

  // Storage is cleared by reset so that contents are defined after rst,
  // which is why every word sits behind the reset branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[addr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_single_port_ram.sv
module tb_single_port_ram;

  localparam int DW = 4;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;

  single_port_ram #(.data_w(DW), .addr_w(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct {
    logic [DW-1:0] exp;
    int            a;
    int            tag;
  } exp_t;

  exp_t   sb_q[$];
  int     vectors = 0;
  int     miscompares = 0;
  int     edge_no = 0;

  // Reference memory: a plain array updated by the spec's rules.
  int     model [DEPTH];

  // One clock of stimulus: drive on the falling edge and predict what
  // data_out must show after the following rising edge.
  task automatic cycle(input logic r, input logic w, input int a, input int d);
    exp_t e;
    @(negedge clk);
    rst     = r;
    we      = w;
    addr    = AW'(a);
    data_in = DW'(d);
    if (r) begin
      foreach (model[i]) model[i] = 0;
      e.exp = '0;
    end else if (w) begin
      model[a] = d % (1 << DW);
      e.exp = DW'(d);
    end else begin
      e.exp = DW'(model[a]);
    end
    e.a   = a;
    e.tag = edge_no;
    edge_no++;
    sb_q.push_back(e);
  endtask

  // Monitor: every rising edge presents one output word.
  initial begin
    exp_t          e;
    logic [DW-1:0] seen;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        seen = data_out;
        vectors++;
        if (data_out !== e.exp) begin
          miscompares++;
          $display("FAIL read vec=%0d addr=%0d got=%h exp=%h", e.tag, e.a, data_out, e.exp);
        end
        #17;
        vectors++;
        if (data_out !== seen) begin
          miscompares++;
          $display("FAIL hold vec=%0d addr=%0d got=%h exp=%h", e.tag, e.a, data_out, seen);
        end
      end
    end
  end

  initial begin
    int r;
    rst = 1'b0; we = 1'b0; addr = '0; data_in = '0;
    foreach (model[i]) model[i] = 0;

    // 1: reset then read every address
    cycle(1, 0, 0, 0);
    for (int a = 0; a < DEPTH; a++) cycle(0, 0, a, 0);
    // 2: write-through and readback
    cycle(0, 1, 0, 7);
    cycle(0, 0, 0, 0);
    // 3: overwrite, neighbour untouched
    cycle(0, 1, 0, 9);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    // 4: pattern fill and sequential read
    for (int a = 0; a < DEPTH; a++) cycle(0, 1, a, a ^ 15);
    for (int a = 0; a < DEPTH; a++) cycle(0, 0, a, 0);
    // 5: data_in ignored when we=0
    cycle(0, 0, 3, 5);
    cycle(0, 0, 3, 0);
    // 6: reset beats a simultaneous write, then re-write works
    cycle(1, 1, 2, 10);
    cycle(0, 0, 2, 0);
    cycle(0, 1, 2, 10);
    cycle(0, 0, 2, 0);
    cycle(0, 0, 3, 0);
    // same address on consecutive edges keeps the last value
    cycle(0, 1, 5, 1);
    cycle(0, 1, 5, 6);
    cycle(0, 0, 5, 0);

    // randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 59);
      cycle((r == 0), $urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
            $urandom_range(0, (1 << DW) - 1));
    end

    @(negedge clk);
    we = 1'b0;
    repeat (3) @(posedge clk);
    #25;
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d exp=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout vectors=%0d exp=finish", vectors);
    $fatal(1, "timeout");
  end

endmodule
